hello_scroller: RTL

HELLO_SCROLLER -- requirements
Module: hello_scroller

---
 rtl/hello_scroller.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/hello_scroller.sv
// -----------------------------------------------------------------------------
// hello_scroller
//
// Scrolls a five-character message, padded by three blanks to an 8-slot ring,
// across eight 7-segment digit codes. Scrolling is either automatic (one step
// per prescaler tick, with an optional pause after each wrap) or manual (one
// step per Step pulse while idle).
//
// Parameters
//   TICK_DIV   : Clock cycles per scroll tick (>= 2)
//   HOLD_TICKS : ticks to pause after each wrap (0 = no pause)
//
// Ports
//   Clock  in   single clock, rising edge
//   Reset  in   synchronous, active-high reset
//   Chars  in   [14:0] five 3-bit codes, Chars[14:12] first, Chars[2:0] last
//   Load   in   capture Chars, rewind to rotation 0
//   Run    in   enable automatic scrolling
//   Dir    in   0 = scroll left (Rot+1), 1 = scroll right (Rot-1)
//   Step   in   manual single advance, honoured only while idle
//   Rot    out  [2:0] current rotation index
//   Disp   out  [23:0] registered digit codes, Disp[3k+2:3k] drives HEXk
//   Wrap   out  one-cycle pulse when a step lands Rot on 0
//   Busy   out  high whenever the scroller is not idle
// -----------------------------------------------------------------------------
module hello_scroller #(
  parameter int TICK_DIV   = 25000000,
  parameter int HOLD_TICKS = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [14:0] Chars,
  input  logic        Load,
  input  logic        Run,
  input  logic        Dir,
  input  logic        Step,
  output logic [2:0]  Rot,
  output logic [23:0] Disp,
  output logic        Wrap,
  output logic        Busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int PW = $clog2(TICK_DIV);
  localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);

  state_t         state;
  logic [14:0]    msg;
  logic [PW-1:0]  presc;
  logic [HW-1:0]  hold_cnt;
  logic           tick;
  logic [2:0]     rot_adv;
  logic [2:0]     ring [8];
  logic [23:0]    disp_next;

  // The prescaler is held at zero while idle, so the state guard only matters
  // for robustness; a tick can never be seen in IDLE.
  assign tick    = (state != IDLE) && (presc == PRESC_LAST);
  assign rot_adv = Dir ? (Rot - 3'd1) : (Rot + 3'd1);
  assign Busy    = (state != IDLE);

  // Ring contents and the digit view for the current rotation. HEX7 shows
  // ring[Rot], HEX0 shows ring[Rot+7]; the 3-bit index wraps mod 8 for free.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    disp_next = '0;
    ring[0]   = 3'b111;
    ring[1]   = 3'b111;
    ring[2]   = 3'b111;
    ring[3]   = msg[14:12];
    ring[4]   = msg[11:9];
    ring[5]   = msg[8:6];
    ring[6]   = msg[5:3];
    ring[7]   = msg[2:0];
    for (int i = 0; i < 8; i++) begin
      disp_next[3*(7-i) +: 3] = ring[3'(i) + Rot];
    end
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      msg      <= 15'h7FFF;
      Rot      <= 3'd0;
      Disp     <= 24'hFFFFFF;
      Wrap     <= 1'b0;
      presc    <= '0;
      hold_cnt <= '0;
    end else begin
      Wrap <= 1'b0;
      // Disp trails any Rot or message change by exactly one cycle.
      Disp <= disp_next;

      if (Load) begin
        // Load outranks tick and Step; a pending pause is abandoned.
        msg      <= Chars;
        Rot      <= 3'd0;
        presc    <= '0;
        hold_cnt <= '0;
        if (state == HOLD) state <= RUN;
      end else begin
        unique case (state)
          IDLE: begin
            presc    <= '0;
            hold_cnt <= '0;
            if (Run) begin
              state <= RUN;
            end else if (Step) begin
              Rot  <= rot_adv;
              Wrap <= (rot_adv == 3'd0);
            end
          end

          RUN: begin
            if (!Run) begin
              state    <= IDLE;
              presc    <= '0;
              hold_cnt <= '0;
            end else begin
              presc <= tick ? '0 : presc + PW'(1);
              if (tick) begin
                Rot  <= rot_adv;
                Wrap <= (rot_adv == 3'd0);
                if (rot_adv == 3'd0 && HOLD_TICKS > 0) begin
                  state    <= HOLD;
                  hold_cnt <= '0;
                end
              end
            end
          end

          HOLD: begin
            if (!Run) begin
              state    <= IDLE;
              presc    <= '0;
              hold_cnt <= '0;
            end else begin
              presc <= tick ? '0 : presc + PW'(1);
              // Rot stays frozen; the last hold tick only returns to RUN,
              // the following tick is the one that advances.
              if (tick) begin
                if (hold_cnt == HOLD_LAST) begin
                  state    <= RUN;
                  hold_cnt <= '0;
                end else begin
                  hold_cnt <= hold_cnt + HW'(1);
                end
              end
            end
          end

          default: begin
            state    <= IDLE;
            presc    <= '0;
            hold_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule
